encoder_3lxnpc: RTL and testbench
=================================

Name: encoder_3lxnpc

Overview:
- Gate-feedback encoder for one 3-level converter leg. It is the inverse of the 3L-ANPC/NPC/NPP gate decoder.
- It samples the six gate-driver feedback signals and reconstructs the applied switching state, which it reports as a `_statesanpc_t` code.
- It measures the dead/transition interval of each commutation and latches shoot-through and dead-timeout faults.
- It sits between the gate-driver status pins and the PS monitoring registers, one instance per leg.

Parameters:
- TOPOLOGY, ANPC, `_npctypes_t`; selects the state table (NPC/NPP use gate_i[3:0] only; gate_i[5:4] are ignored).
- SYNC_STAGES, 2, number of synchroniser flops on gate_i (minimum 2).
- FILT_CYC, 4, consecutive identical synchronised samples required before a pattern is accepted (range 1..15).
- MAX_DEAD, 200, transition-interval limit in clk cycles; exceeding it raises a timeout fault.
- TDELAY_WIDTH, `` `TDELAY_WIDTH `` (8), width of deadtime_o.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset.
- gate_i, in, 6, feedback {S6,S5,S4,S3,S2,S1}; S1/S4 outer, S2/S3 inner, S5/S6 clamp (ANPC).
- clr_i, in, 1, clears a latched fault (level, sampled).
- state_o, out, 3, last accepted state, `_statesanpc_t` encoding.
- state_valid_o, out, 1, high once a table state has been accepted; low in FAULT.
- comm_o, out, 1, one-cycle pulse on each accepted state change.
- prev_state_o, out, 3, state held before the last commutation.
- deadtime_o, out, TDELAY_WIDTH, cycles spent outside a table state in the last commutation; saturating.
- fault_o, out, 1, sticky fault flag.
- fault_code_o, out, 2, 0 = none, 1 = shoot-through, 2 = dead timeout.

Behaviour:
- Interface (already decided): one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state_o = P, prev_state_o = P, state_valid_o = 0, comm_o = 0, deadtime_o = 0, fault_o = 0, fault_code_o = 0. Synchroniser flops and filter counter are cleared.
- Pipeline: gate_i → SYNC_STAGES flops → filter. A pattern is accepted when it has been identical for FILT_CYC samples. Total latency from a gate_i edge to a state_o/comm_o update is SYNC_STAGES + FILT_CYC cycles.
- ANPC table (on-set; all other switches off):
  - P = S1,S2,S6
  - Z_U2 = S2,S5,S4
  - Z_U1 = S2,S5
  - Z_L1 = S3,S6
  - Z_L2 = S3,S6,S1
  - N = S3,S4,S5
- NPC/NPP table:
  - P = S1,S2
  - Z_U1 = S2,S3 (ZZ)
  - N = S3,S4
- Hazard patterns, combinational on the synchronised value and unfiltered:
  - ANPC: S1&S5, S4&S6, S1&S2&S3&S4.
  - NPC/NPP: S1&S3, S2&S4, S1&S2&S3&S4.
- Other non-table patterns, including all-off, are transitional.
- FSM states: INIT, STABLE, TRANS, FAULT.
  - INIT: wait until a table pattern is accepted → STABLE, with state_valid_o = 1. No comm_o is issued.
  - STABLE: the synchronised pattern differs from state_o → TRANS, dead counter = 1. An accepted pattern equal to state_o leaves the FSM in STABLE.
  - TRANS: the counter increments each cycle while the pattern is non-table or unfiltered, saturating at 2^TDELAY_WIDTH-1.
    - If a new table state S is accepted: comm_o = 1 for one cycle, prev_state_o = old state_o, state_o = S, deadtime_o = counter − FILT_CYC (floor 0, saturated), → STABLE.
    - If the pattern is accepted back at the original state (glitch), → STABLE with no comm_o; deadtime_o is unchanged.
    - If the counter exceeds MAX_DEAD, → FAULT with code 2.
  - Any state: a hazard pattern → FAULT, code 1, on the next clock edge. Hazard detection has priority over timeout and over acceptance in the same cycle.
  - FAULT: fault_o = 1 and state_valid_o = 0; state_o holds its last value and comm_o stays 0.
    - clr_i = 1 with a non-hazard synchronised pattern → INIT and clears fault_o/fault_code_o.
    - clr_i asserted while the hazard persists is ignored.
- Filter: the counter restarts at 1 whenever the synchronised sample changes.
- Reset asserted mid-commutation returns all outputs to reset values immediately, with no comm_o.

Decomposition:
- Add to PKG_decoder_3lxnpc:
  - state-table constants (per-topology on-patterns as 6-bit localparams),
  - hazard masks,
  - `_encfault_t` enum {F_NONE, F_SHOOT, F_DEAD},
  - `_encfsm_t` enum {INIT, STABLE, TRANS, FAULT}.
  - Reuse `_statesanpc_t` and `_npctypes_t`.
- One sub-module: `sync_filter_3lxnpc` (parameterised width, SYNC_STAGES, FILT_CYC). It outputs the synchronised vector and an accepted-pattern strobe.

Test Plan:
- Reset, then hold gate_i = 6'b100011 (P) for 10 cycles → state_o = P, state_valid_o = 1 after 6 cycles; no comm_o.
- From P, drive 6'b000010 for 20 cycles, then 6'b011010 (Z_U2) → one comm_o, prev_state_o = P, state_o = Z_U2, deadtime_o = 20 (±1 for sync phase).
- From P, apply a 2-cycle pulse of 6'b000000, then return to P → filter rejects it; no comm_o; state_o stays P.
- Apply 6'b010001 (S1&S5) for one cycle → fault_o = 1, fault_code_o = 1, state_valid_o = 0. clr_i while still 6'b010001 → fault remains. Then P with clr_i → INIT, then P accepted.
- With MAX_DEAD = 200, hold all-off for 250 cycles after P → fault_code_o = 2 at cycle 201 of TRANS.
- TOPOLOGY = NPC: sequence 6'bxx0011 → xx0110 → xx1100 → state_o P, Z_U1, N with two comm_o pulses; gate_i[5:4] toggling has no effect.

Source files
------------

// File: rtl/encoder_3lxnpc_pkg.sv
// Shared types, gate on-pattern tables and lookup helpers for the 3-level leg feedback encoder.
// Gate vectors are ordered {S6,S5,S4,S3,S2,S1}.
package encoder_3lxnpc_pkg;

   typedef enum logic [1:0] {
      TopoAnpc = 2'd0,
      TopoNpc  = 2'd1,
      TopoNpp  = 2'd2
   } npctypes_t;

   typedef enum logic [2:0] {
      StateP   = 3'd0,
      StateZU2 = 3'd1,
      StateZU1 = 3'd2,
      StateZL1 = 3'd3,
      StateZL2 = 3'd4,
      StateN   = 3'd5
   } statesanpc_t;

   typedef enum logic [1:0] {
      FaultNone  = 2'd0,
      FaultShoot = 2'd1,
      FaultDead  = 2'd2
   } encfault_t;

   typedef enum logic [1:0] {
      StInit   = 2'd0,
      StStable = 2'd1,
      StTrans  = 2'd2,
      StFault  = 2'd3
   } encfsm_t;

   localparam int unsigned DefTdelayWidth = 8;

   localparam logic [5:0] AnpcPatP   = 6'b100011;
   localparam logic [5:0] AnpcPatZU2 = 6'b011010;
   localparam logic [5:0] AnpcPatZU1 = 6'b010010;
   localparam logic [5:0] AnpcPatZL1 = 6'b100100;
   localparam logic [5:0] AnpcPatZL2 = 6'b100101;
   localparam logic [5:0] AnpcPatN   = 6'b011100;

   localparam logic [5:0] NpcMask    = 6'b001111;
   localparam logic [5:0] NpcPatP    = 6'b000011;
   localparam logic [5:0] NpcPatZ    = 6'b000110;
   localparam logic [5:0] NpcPatN    = 6'b001100;

   localparam logic [5:0] AnpcHazOuterClampU = 6'b010001;
   localparam logic [5:0] AnpcHazOuterClampL = 6'b101000;
   localparam logic [5:0] HazAllSeries       = 6'b001111;
   localparam logic [5:0] NpcHazUpper        = 6'b000101;
   localparam logic [5:0] NpcHazLower        = 6'b001010;

   typedef struct packed {
      logic        hit;
      statesanpc_t st;
   } lookup_t;

   function automatic lookup_t table_lookup(npctypes_t topo, logic [5:0] pat);
      lookup_t res;
      res.hit = 1'b1;
      res.st  = StateP;
      if (topo == TopoAnpc) begin
         case (pat)
            AnpcPatP:   res.st = StateP;
            AnpcPatZU2: res.st = StateZU2;
            AnpcPatZU1: res.st = StateZU1;
            AnpcPatZL1: res.st = StateZL1;
            AnpcPatZL2: res.st = StateZL2;
            AnpcPatN:   res.st = StateN;
            default:    res.hit = 1'b0;
         endcase
      end else begin
         case (pat & NpcMask)
            NpcPatP: res.st = StateP;
            NpcPatZ: res.st = StateZU1;
            NpcPatN: res.st = StateN;
            default: res.hit = 1'b0;
         endcase
      end
      return res;
   endfunction

   function automatic logic [5:0] state_pattern(npctypes_t topo, statesanpc_t st);
      logic [5:0] pat;
      pat = 6'b000000;
      if (topo == TopoAnpc) begin
         case (st)
            StateP:   pat = AnpcPatP;
            StateZU2: pat = AnpcPatZU2;
            StateZU1: pat = AnpcPatZU1;
            StateZL1: pat = AnpcPatZL1;
            StateZL2: pat = AnpcPatZL2;
            StateN:   pat = AnpcPatN;
            default:  pat = 6'b000000;
         endcase
      end else begin
         case (st)
            StateP:   pat = NpcPatP;
            StateZU1: pat = NpcPatZ;
            StateN:   pat = NpcPatN;
            default:  pat = 6'b000000;
         endcase
      end
      return pat;
   endfunction

   function automatic logic is_hazard(npctypes_t topo, logic [5:0] pat);
      logic [5:0] p;
      if (topo == TopoAnpc) begin
         return ((pat & AnpcHazOuterClampU) == AnpcHazOuterClampU) ||
                ((pat & AnpcHazOuterClampL) == AnpcHazOuterClampL) ||
                ((pat & HazAllSeries) == HazAllSeries);
      end
      p = pat & NpcMask;
      return ((p & NpcHazUpper) == NpcHazUpper) ||
             ((p & NpcHazLower) == NpcHazLower) ||
             ((p & HazAllSeries) == HazAllSeries);
   endfunction

endpackage

// File: rtl/encoder_3lxnpc_sync.sv
// Multi-stage synchroniser followed by a consecutive-sample filter; acc_o is high while the
// synchronised vector has been identical for at least FiltCyc samples (current one included).
module sync_filter_3lxnpc #(
   parameter int unsigned Width      = 6,
   parameter int unsigned SyncStages = 2,
   parameter int unsigned FiltCyc    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] sync_o,
   output logic             acc_o
);

   localparam int unsigned Stages  = (SyncStages < 2) ? 2 : SyncStages;
   localparam int unsigned FiltEff = (FiltCyc == 0) ? 1 : ((FiltCyc > 15) ? 15 : FiltCyc);
   localparam logic [3:0]  FiltThr = 4'(FiltEff);

   logic [Width-1:0] sync_q [Stages];
   logic [Width-1:0] last_q;
   logic [3:0]       cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Stages; i++) begin
            sync_q[i] <= '0;
         end
         last_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q[0] <= data_i;
         for (int i = 1; i < Stages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         last_q <= sync_o;
         cnt_q  <= cnt_d;
      end
   end

   assign sync_o = sync_q[Stages-1];

   // Count of consecutive identical samples including the one presented this cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (sync_o != last_q) begin
         cnt_d = 4'd1;
      end else if (cnt_q != 4'hf) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   assign acc_o = (cnt_d >= FiltThr);

endmodule

// File: rtl/encoder_3lxnpc.sv
// Gate-feedback encoder for one 3-level leg: rebuilds the applied switching state, measures
// commutation dead intervals and latches shoot-through / dead-timeout faults.
module encoder_3lxnpc
   import encoder_3lxnpc_pkg::*;
#(
   parameter npctypes_t   Topology    = TopoAnpc,
   parameter int unsigned SyncStages  = 2,
   parameter int unsigned FiltCyc     = 4,
   parameter int unsigned MaxDead     = 200,
   parameter int unsigned TdelayWidth = DefTdelayWidth
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [5:0]             gate_i,
   input  logic                   clr_i,
   output logic [2:0]             state_o,
   output logic                   state_valid_o,
   output logic                   comm_o,
   output logic [2:0]             prev_state_o,
   output logic [TdelayWidth-1:0] deadtime_o,
   output logic                   fault_o,
   output logic [1:0]             fault_code_o
);

   localparam int unsigned FiltEff = (FiltCyc == 0) ? 1 : ((FiltCyc > 15) ? 15 : FiltCyc);
   localparam logic [5:0]  InMask  = (Topology == TopoAnpc) ? 6'b111111 : NpcMask;
   localparam logic [TdelayWidth-1:0] DeadSat = '1;

   logic [5:0] gate_m, sync_pat;
   logic       acc;
   lookup_t    lk;
   logic       hazard, same_pat, timeout;

   encfsm_t                fsm_q, fsm_d;
   statesanpc_t            state_q, state_d, prev_q, prev_d;
   logic [TdelayWidth-1:0] dead_q, dead_d, dead_inc, dtime_q, dtime_d, dtime_new;
   logic                   comm_q, comm_d;
   encfault_t              code_q, code_d;

   // Unused gate bits are dropped before the synchroniser so they cannot reset the filter.
   assign gate_m = gate_i & InMask;

   sync_filter_3lxnpc #(
      .Width      (6),
      .SyncStages (SyncStages),
      .FiltCyc    (FiltEff)
   ) u_sync_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (gate_m),
      .sync_o (sync_pat),
      .acc_o  (acc)
   );

   assign lk       = table_lookup(Topology, sync_pat);
   assign hazard   = is_hazard(Topology, sync_pat);
   assign same_pat = (sync_pat == state_pattern(Topology, state_q));

   assign dead_inc  = (dead_q == DeadSat) ? dead_q : dead_q + 1'b1;
   assign timeout   = (32'(dead_inc) > MaxDead);
   // Filter latency is part of the measured interval, so it is removed from the report.
   assign dtime_new = (32'(dead_inc) > FiltEff) ? TdelayWidth'(32'(dead_inc) - FiltEff) : '0;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      prev_d  = prev_q;
      dead_d  = dead_q;
      dtime_d = dtime_q;
      comm_d  = 1'b0;
      code_d  = code_q;
      if (hazard) begin
         fsm_d  = StFault;
         code_d = FaultShoot;
      end else begin
         unique case (fsm_q)
            StInit: begin
               if (acc && lk.hit) begin
                  fsm_d   = StStable;
                  state_d = lk.st;
               end
            end
            StStable: begin
               if (!same_pat) begin
                  fsm_d  = StTrans;
                  dead_d = TdelayWidth'(1);
               end
            end
            StTrans: begin
               dead_d = dead_inc;
               if (acc && same_pat) begin
                  fsm_d = StStable;
               end else if (acc && lk.hit) begin
                  fsm_d   = StStable;
                  comm_d  = 1'b1;
                  prev_d  = state_q;
                  state_d = lk.st;
                  dtime_d = dtime_new;
               end else if (timeout) begin
                  fsm_d  = StFault;
                  code_d = FaultDead;
               end
            end
            StFault: begin
               if (clr_i) begin
                  fsm_d  = StInit;
                  code_d = FaultNone;
               end
            end
            default: fsm_d = StInit;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= StInit;
         state_q <= StateP;
         prev_q  <= StateP;
         dead_q  <= '0;
         dtime_q <= '0;
         comm_q  <= 1'b0;
         code_q  <= FaultNone;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         prev_q  <= prev_d;
         dead_q  <= dead_d;
         dtime_q <= dtime_d;
         comm_q  <= comm_d;
         code_q  <= code_d;
      end
   end

   assign state_o       = state_q;
   assign prev_state_o  = prev_q;
   assign state_valid_o = (fsm_q == StStable) || (fsm_q == StTrans);
   assign comm_o        = comm_q;
   assign deadtime_o    = dtime_q;
   assign fault_o       = (fsm_q == StFault);
   assign fault_code_o  = code_q;

endmodule

// File: tb/tb_encoder_3lxnpc.sv
// Directed bench: one ANPC instance and one NPC instance driven through commutations,
// glitches, shoot-through, dead-timeout and mid-commutation reset.
module tb_encoder_3lxnpc;
   import encoder_3lxnpc_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic [5:0] gate_a, gate_b;

   logic [2:0] state_a, prev_a, state_b, prev_b;
   logic       valid_a, comm_a, fault_a, valid_b, comm_b, fault_b;
   logic [1:0] code_a, code_b;
   logic [7:0] dead_a, dead_b;

   int checks = 0;
   int errors = 0;
   int ncomm_a = 0;
   int ncomm_b = 0;

   encoder_3lxnpc #(
      .Topology (TopoAnpc)
   ) u_dut_anpc (
      .clk           (clk),
      .rst_n         (rst_n),
      .gate_i        (gate_a),
      .clr_i         (clr),
      .state_o       (state_a),
      .state_valid_o (valid_a),
      .comm_o        (comm_a),
      .prev_state_o  (prev_a),
      .deadtime_o    (dead_a),
      .fault_o       (fault_a),
      .fault_code_o  (code_a)
   );

   encoder_3lxnpc #(
      .Topology (TopoNpc)
   ) u_dut_npc (
      .clk           (clk),
      .rst_n         (rst_n),
      .gate_i        (gate_b),
      .clr_i         (clr),
      .state_o       (state_b),
      .state_valid_o (valid_b),
      .comm_o        (comm_b),
      .prev_state_o  (prev_b),
      .deadtime_o    (dead_b),
      .fault_o       (fault_b),
      .fault_code_o  (code_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (comm_a) ncomm_a <= ncomm_a + 1;
      if (comm_b) ncomm_b <= ncomm_b + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      clr    = 1'b0;
      gate_a = 6'b000000;
      gate_b = 6'b000000;
      tick(2);
      chk("rst_state", state_a, StateP);
      chk("rst_prev", prev_a, StateP);
      chk("rst_valid", valid_a, 0);
      chk("rst_comm", comm_a, 0);
      chk("rst_dead", dead_a, 0);
      chk("rst_fault", fault_a, 0);
      chk("rst_code", code_a, 0);

      // First acceptance of P: SyncStages + FiltCyc = 6 cycles, no comm pulse
      rst_n  = 1'b1;
      gate_a = AnpcPatP;
      tick(5);
      chk("init_valid_early", valid_a, 0);
      tick(1);
      chk("init_valid", valid_a, 1);
      chk("init_state", state_a, StateP);
      tick(4);
      chk("init_no_comm", ncomm_a, 0);

      // P -> Z_U2 with 20 cycles of S2-only in between
      gate_a = 6'b000010;
      tick(20);
      chk("trans_valid", valid_a, 1);
      gate_a = AnpcPatZU2;
      tick(5);
      chk("zu2_not_yet", state_a, StateP);
      tick(1);
      chk("zu2_comm", comm_a, 1);
      chk("zu2_state", state_a, StateZU2);
      chk("zu2_prev", prev_a, StateP);
      chk("zu2_dead", dead_a, 20);
      tick(1);
      chk("zu2_comm_pulse", comm_a, 0);
      chk("zu2_ncomm", ncomm_a, 1);

      // Two-cycle all-off glitch from Z_U2 is rejected, deadtime unchanged
      gate_a = 6'b000000;
      tick(2);
      gate_a = AnpcPatZU2;
      tick(10);
      chk("glitch1_state", state_a, StateZU2);
      chk("glitch1_dead", dead_a, 20);
      chk("glitch1_ncomm", ncomm_a, 1);

      // Direct Z_U2 -> P: interval equals filter latency, reported as 0
      gate_a = AnpcPatP;
      tick(6);
      chk("p_comm", comm_a, 1);
      chk("p_state", state_a, StateP);
      chk("p_prev", prev_a, StateZU2);
      chk("p_dead", dead_a, 0);
      tick(1);

      // Two-cycle all-off glitch from P
      gate_a = 6'b000000;
      tick(2);
      gate_a = AnpcPatP;
      tick(10);
      chk("glitch2_state", state_a, StateP);
      chk("glitch2_valid", valid_a, 1);
      chk("glitch2_ncomm", ncomm_a, 2);

      // One-cycle S1&S5 shoot-through is caught unfiltered and latched
      gate_a = AnpcHazOuterClampU;
      tick(1);
      gate_a = AnpcPatP;
      tick(1);
      chk("shoot_early", fault_a, 0);
      tick(1);
      chk("shoot_fault", fault_a, 1);
      chk("shoot_code", code_a, 1);
      chk("shoot_valid", valid_a, 0);
      chk("shoot_hold_state", state_a, StateP);
      tick(3);
      chk("shoot_sticky", fault_a, 1);

      // Clear ignored while the hazard persists
      gate_a = AnpcHazOuterClampU;
      tick(3);
      clr = 1'b1;
      tick(4);
      chk("clr_haz_fault", fault_a, 1);
      chk("clr_haz_code", code_a, 1);
      gate_a = AnpcPatP;
      tick(2);
      chk("clr_pipe_fault", fault_a, 1);
      tick(1);
      chk("clr_fault", fault_a, 0);
      chk("clr_code", code_a, 0);
      chk("clr_valid", valid_a, 0);
      clr = 1'b0;
      tick(2);
      chk("reinit_early", valid_a, 0);
      tick(1);
      chk("reinit_valid", valid_a, 1);
      chk("reinit_state", state_a, StateP);
      chk("reinit_ncomm", ncomm_a, 2);

      // Dead timeout: TRANS entered at edge 3, counter passes 200 -> fault at edge 203
      gate_a = 6'b000000;
      tick(202);
      chk("tmo_early", fault_a, 0);
      chk("tmo_early_valid", valid_a, 1);
      tick(1);
      chk("tmo_fault", fault_a, 1);
      chk("tmo_code", code_a, 2);
      chk("tmo_valid", valid_a, 0);
      chk("tmo_state", state_a, StateP);

      gate_a = AnpcPatP;
      clr    = 1'b1;
      tick(1);
      chk("tmo_clr", fault_a, 0);
      chk("tmo_clr_code", code_a, 0);
      clr = 1'b0;
      tick(5);
      chk("tmo_reinit", valid_a, 1);

      // P -> Z_L2, then reset in the middle of the next commutation
      gate_a = AnpcPatZL2;
      tick(6);
      chk("zl2_comm", comm_a, 1);
      chk("zl2_state", state_a, StateZL2);
      chk("zl2_prev", prev_a, StateP);
      gate_a = AnpcPatN;
      tick(3);
      chk("mid_valid", valid_a, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", state_a, StateP);
      chk("mid_rst_prev", prev_a, StateP);
      chk("mid_rst_valid", valid_a, 0);
      chk("mid_rst_comm", comm_a, 0);
      chk("mid_rst_dead", dead_a, 0);
      chk("mid_rst_fault", fault_a, 0);

      // NPC: gate_i[5:4] are don't-care
      tick(1);
      rst_n  = 1'b1;
      gate_a = 6'b000000;
      gate_b = 6'b110011;
      tick(5);
      chk("npc_valid_early", valid_b, 0);
      tick(1);
      chk("npc_valid", valid_b, 1);
      chk("npc_state_p", state_b, StateP);
      for (int i = 0; i < 8; i++) begin
         gate_b = {2'(i), 4'b0011};
         tick(1);
      end
      chk("npc_toggle_ncomm", ncomm_b, 0);
      chk("npc_toggle_state", state_b, StateP);
      chk("npc_toggle_fault", fault_b, 0);

      gate_b = 6'b010110;
      tick(6);
      chk("npc_zz_comm", comm_b, 1);
      chk("npc_zz_state", state_b, StateZU1);
      chk("npc_zz_prev", prev_b, StateP);
      chk("npc_zz_dead", dead_b, 0);
      tick(1);

      for (int i = 0; i < 6; i++) begin
         gate_b = {2'(i), 4'b1100};
         tick(1);
      end
      chk("npc_n_comm", comm_b, 1);
      chk("npc_n_state", state_b, StateN);
      chk("npc_n_prev", prev_b, StateZU1);
      tick(1);
      chk("npc_ncomm", ncomm_b, 2);

      gate_b = 6'b000101;
      tick(3);
      chk("npc_shoot_fault", fault_b, 1);
      chk("npc_shoot_code", code_b, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
